// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: widths, opcodes,
// step encoding and instruction field positions.
package proc_pkg;
  localparam int IR_W   = 9;
  localparam int N_REGS = 8;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;
endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control interface between the sequencer (master) and the datapath (slave).
interface proc_ctrl_fsm_if;
  import proc_pkg::*;

  logic              Run;
  logic [IR_W-1:0]   DIN;
  logic [0:N_REGS-1] Rin;
  logic [0:N_REGS-1] Rout;
  logic              DINout;
  logic              Gout;
  logic              Ain;
  logic              Gin;
  logic              AddSub;
  logic              Done;

  modport master (
    input  Run, DIN,
    output Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done
  );

  modport slave (
    output Run, DIN,
    input  Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done
  );
endinterface

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; W=000 selects Y[0].
module dec3to8 (
  input  logic [2:0] W,
  input  logic       En,
  output logic [0:7] Y
);
  always_comb begin
    Y = '0;
    if (En) Y[W] = 1'b1;
  end
endmodule

// File: rtl/proc_ctrl_fsm.sv
// Instruction sequencer: fetches IIIXXXYYY on Run in T0, then walks T1..T3
// driving bus selects and load strobes decoded straight from state and IR.
module proc_ctrl_fsm
  import proc_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  proc_ctrl_fsm_if.master  bus
);
  state_t          state;
  logic [IR_W-1:0] ir;
  logic [2:0]      op, fx, fy, rout_sel;
  logic            is_arith;
  logic            mv_t1, mvi_t1, nop_t1, ar_t1, ar_t2, ar_t3;
  logic            rin_en, rout_en;
  logic [0:7]      rin, rout;

  assign op       = ir[OP_MSB:OP_LSB];
  assign fx       = ir[X_MSB:X_LSB];
  assign fy       = ir[Y_MSB:Y_LSB];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      case (state)
        T0: if (bus.Run) begin
              ir    <= bus.DIN;
              state <= T1;
            end
        T1:      state <= is_arith ? T2 : T0;
        T2:      state <= T3;
        default: state <= T0;
      endcase
    end
  end

  assign mv_t1  = (state == T1) && (op == OP_MV);
  assign mvi_t1 = (state == T1) && (op == OP_MVI);
  assign nop_t1 = (state == T1) && op[2];
  assign ar_t1  = (state == T1) && is_arith;
  assign ar_t2  = (state == T2) && is_arith;
  assign ar_t3  = (state == T3) && is_arith;

  // Rout sources Y for mv and the second add/sub operand, X otherwise.
  assign rin_en   = mv_t1 | mvi_t1 | ar_t3;
  assign rout_en  = mv_t1 | ar_t1 | ar_t2;
  assign rout_sel = (mv_t1 | ar_t2) ? fy : fx;

  dec3to8 u_dec_rin  (.W(fx),       .En(rin_en),  .Y(rin));
  dec3to8 u_dec_rout (.W(rout_sel), .En(rout_en), .Y(rout));

  assign bus.Rin    = rin;
  assign bus.Rout   = rout;
  assign bus.DINout = mvi_t1;
  assign bus.Gout   = ar_t3;
  assign bus.Ain    = ar_t1;
  assign bus.Gin    = ar_t2;
  assign bus.AddSub = ar_t2 & (op == OP_SUB);
  assign bus.Done   = mv_t1 | mvi_t1 | nop_t1 | ar_t3;
endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed and randomized checks of the processor control sequencer.
module tb_proc_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [5:0] F_DIN  = 6'b100000;
  localparam logic [5:0] F_G    = 6'b010000;
  localparam logic [5:0] F_A    = 6'b001000;
  localparam logic [5:0] F_GIN  = 6'b000100;
  localparam logic [5:0] F_SUB  = 6'b000010;
  localparam logic [5:0] F_DONE = 6'b000001;

  proc_ctrl_fsm_if bus ();

  proc_ctrl_fsm u_dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  wire [21:0] outv = {bus.Rin, bus.Rout, bus.DINout, bus.Gout,
                      bus.Ain, bus.Gin, bus.AddSub, bus.Done};

  function automatic logic [21:0] pk(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic [5:0] f);
    return {rin, rout, f};
  endfunction

  // Reference outputs from a step count (0 = idle) and the latched instruction.
  function automatic logic [21:0] exp_out(input int step, input logic [8:0] ir);
    logic [2:0] op;
    logic [7:0] hx, hy;
    op = ir[8:6];
    hx = 8'h80 >> ir[5:3];
    hy = 8'h80 >> ir[2:0];
    case (step)
      1: case (op)
           3'd0:       return pk(hx, hy, F_DONE);
           3'd1:       return pk(hx, 8'h00, F_DIN | F_DONE);
           3'd2, 3'd3: return pk(8'h00, hx, F_A);
           default:    return pk(8'h00, 8'h00, F_DONE);
         endcase
      2: return pk(8'h00, hy, F_GIN | ((op == 3'd3) ? F_SUB : 6'b0));
      3: return pk(hx, 8'h00, F_G | F_DONE);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         step;
    logic [8:0] mir;
    int         drivers;

    bus.Run = 1'b0;
    bus.DIN = '0;
    #3;
    chk("reset_idle", 32'(outv), 32'(pk(8'h00, 8'h00, 6'b0)));
    #9;
    rst_n = 1'b1;

    // mv R3,R5
    bus.Run = 1'b1; bus.DIN = 9'b000_011_101;
    tick(); bus.Run = 1'b0;
    chk("mv_t1", 32'(outv), 32'(pk(8'b0001_0000, 8'b0000_0100, F_DONE)));
    tick();
    chk("mv_t0", 32'(outv), 32'd0);

    // mvi R7,#D
    bus.Run = 1'b1; bus.DIN = 9'b001_111_000;
    tick(); bus.Run = 1'b0; bus.DIN = 9'h05A;
    chk("mvi_t1", 32'(outv), 32'(pk(8'b0000_0001, 8'h00, F_DIN | F_DONE)));
    tick();
    chk("mvi_t0", 32'(outv), 32'd0);

    // add R0,R1
    bus.Run = 1'b1; bus.DIN = 9'b010_000_001;
    tick(); bus.Run = 1'b0;
    chk("add_t1", 32'(outv), 32'(pk(8'h00, 8'b1000_0000, F_A)));
    tick();
    chk("add_t2", 32'(outv), 32'(pk(8'h00, 8'b0100_0000, F_GIN)));
    tick();
    chk("add_t3", 32'(outv), 32'(pk(8'b1000_0000, 8'h00, F_G | F_DONE)));
    tick();
    chk("add_t0", 32'(outv), 32'd0);

    // sub R2,R6 with Run dropped in T1; new DIN must not disturb IR
    bus.Run = 1'b1; bus.DIN = 9'b011_010_110;
    tick(); bus.Run = 1'b0; bus.DIN = 9'b000_111_111;
    chk("sub_t1", 32'(outv), 32'(pk(8'h00, 8'b0010_0000, F_A)));
    tick();
    chk("sub_t2", 32'(outv), 32'(pk(8'h00, 8'b0000_0010, F_GIN | F_SUB)));
    tick();
    chk("sub_t3", 32'(outv), 32'(pk(8'b0010_0000, 8'h00, F_G | F_DONE)));
    tick();
    chk("sub_idle0", 32'(outv), 32'd0);
    tick();
    chk("sub_idle1", 32'(outv), 32'd0);

    // add R2,R2: same register on both operands
    bus.Run = 1'b1; bus.DIN = 9'b010_010_010;
    tick(); bus.Run = 1'b0;
    chk("rr_t1", 32'(outv), 32'(pk(8'h00, 8'b0010_0000, F_A)));
    tick();
    chk("rr_t2", 32'(outv), 32'(pk(8'h00, 8'b0010_0000, F_GIN)));
    tick();
    chk("rr_t3", 32'(outv), 32'(pk(8'b0010_0000, 8'h00, F_G | F_DONE)));
    tick();

    // Reset during T2 of add R0,R1
    bus.Run = 1'b1; bus.DIN = 9'b010_000_001;
    tick(); bus.Run = 1'b0;
    tick();
    chk("pre_rst_t2", 32'(outv), 32'(pk(8'h00, 8'b0100_0000, F_GIN)));
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(outv), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", 32'(outv), 32'd0);
    end

    // Reserved opcode back-to-back with Run held high
    bus.Run = 1'b1; bus.DIN = 9'b101_000_000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("nop_b2b", 32'(outv), 32'(pk(8'h00, 8'h00, (i % 2 == 0) ? F_DONE : 6'b0)));
    end
    bus.Run = 1'b0;

    // Randomized mix against a step-count model plus bus invariants
    step = 0;
    mir  = '0;
    for (int i = 0; i < 300; i++) begin
      bus.Run = 1'($urandom_range(0, 1));
      bus.DIN = 9'($urandom);
      @(posedge clk);
      case (step)
        0: if (bus.Run) begin mir = bus.DIN; step = 1; end
        1: step = (mir[8:7] == 2'b01) ? 2 : 0;
        2: step = 3;
        default: step = 0;
      endcase
      #1;
      chk("rand_out", 32'(outv), 32'(exp_out(step, mir)));
      drivers = $countones(bus.Rout) + int'(bus.DINout) + int'(bus.Gout);
      chk("bus_one_driver", 32'(drivers <= 1), 32'd1);
      chk("rin_onehot", 32'($countones(bus.Rin) <= 1), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
